// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//
// Purpose
//   This is a WIDTH-generic multi-cycle ALU with registered outputs and a
//   start/done handshake.
//   - ADD, SUB, AND, OR, XOR and NOT complete in one cycle.
//   - MUL is an unsigned shift-add multiplier. It takes WIDTH cycles and
//     returns a 2*WIDTH-bit product.
//   - Opcode 111 is reserved. It completes in one cycle with err=1.
//
// Configuration
//   SEQ_ALU_MUL_EN  When defined, the MUL state, the accumulator and the step
//                   counter are built.
//                   When undefined, no multiplier is built, busy is tied low
//                   and opcode 110 behaves like the reserved opcode.
//
// Ports
//   clk     in   1        rising-edge clock
//   reset   in   1        asynchronous, active-high; clears all state
//   start   in   1        request, sampled only while busy=0
//   op      in   3        opcode, latched on acceptance
//   a, b    in   WIDTH    operands, latched on acceptance
//   busy    out  1        a MUL is in progress
//   done    out  1        one-cycle pulse when result/flags update
//   result  out  2*WIDTH  registered result, held until the next done
//   carry   out  1        ADD carry out / SUB no-borrow, else 0
//   zero    out  1        result is all zero
//   err     out  1        the last accepted op was reserved
// -----------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero,
  output logic               err
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_MUL = 3'b110,
    OP_RSV = 3'b111
  } op_e;

  localparam logic [WIDTH:0] ONE_EXT = 1;

  // Output registers
  logic [2*WIDTH-1:0] r_result;
  logic               r_carry;
  logic               r_zero;
  logic               r_err;
  logic               r_done;

  // Next-state values
  logic [2*WIDTH-1:0] w_result_nxt;
  logic               w_carry_nxt;
  logic               w_zero_nxt;
  logic               w_err_nxt;
  logic               w_done_nxt;

  // Single-cycle datapath, driven straight from the input operands
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_op_res;
  logic               w_op_carry;
  logic               w_op_err;

  // NOTE: every signal assigned in an always_comb gets a default value first.
  // This way, no path through the case statements can leave a signal
  // unassigned and infer a latch.
  always_comb begin
    w_sum      = '0;
    w_op_res   = '0;
    w_op_carry = 1'b0;
    w_op_err   = 1'b0;
    case (op)
      OP_ADD: begin
        w_sum      = {1'b0, a} + {1'b0, b};
        w_op_res   = w_sum[WIDTH-1:0];
        w_op_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        // Two's-complement subtract. Bit WIDTH of the sum is the no-borrow
        // flag, so it is 1 exactly when a >= b.
        w_sum      = {1'b0, a} + {1'b0, ~b} + ONE_EXT;
        w_op_res   = w_sum[WIDTH-1:0];
        w_op_carry = w_sum[WIDTH];
      end
      OP_AND:  w_op_res = a & b;
      OP_OR:   w_op_res = a | b;
      OP_XOR:  w_op_res = a ^ b;
      OP_NOT:  w_op_res = ~a;
      // This covers the reserved opcode. It also covers MUL when the
      // multiplier is not built, and in that case MUL behaves as reserved.
      default: w_op_err = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  localparam int CW = $clog2(WIDTH + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  // The upper half of the accumulator holds the partial product. The lower
  // half holds the multiplier, which shifts out LSB-first.
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   w_mcand_nxt;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      w_count_nxt;
  logic [CW-1:0]      w_count_inc;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_acc;

  // One shift-add step. The carry out of the adder shifts into the top bit,
  // so the product never loses a bit.
  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_acc   = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_count_inc = r_count + CW'(1);

  assign busy = (r_state == S_MUL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_mcand <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_mcand <= w_mcand_nxt;
      r_count <= w_count_nxt;
    end
  end
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    w_result_nxt = r_result;
    w_carry_nxt  = r_carry;
    w_zero_nxt   = r_zero;
    w_err_nxt    = r_err;
    w_done_nxt   = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_count_nxt  = r_count;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            w_state_nxt = S_MUL;
            w_acc_nxt   = {{WIDTH{1'b0}}, b};
            w_mcand_nxt = a;
            w_count_nxt = '0;
          end else begin
            w_result_nxt = {{WIDTH{1'b0}}, w_op_res};
            w_carry_nxt  = w_op_carry;
            w_zero_nxt   = (w_op_res == '0);
            w_err_nxt    = w_op_err;
            w_done_nxt   = 1'b1;
          end
        end
      end
      S_MUL: begin
        // A start that arrives in this state is simply not looked at.
        w_acc_nxt   = w_mul_acc;
        w_count_nxt = w_count_inc;
        if (w_count_inc == CW'(WIDTH)) begin
          w_result_nxt = w_mul_acc;
          w_carry_nxt  = 1'b0;
          w_zero_nxt   = (w_mul_acc == '0);
          w_err_nxt    = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
`else
    if (start) begin
      w_result_nxt = {{WIDTH{1'b0}}, w_op_res};
      w_carry_nxt  = w_op_carry;
      w_zero_nxt   = (w_op_res == '0);
      w_err_nxt    = w_op_err;
      w_done_nxt   = 1'b1;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples the values from before the edge, regardless of the order of the
  // statements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b1;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_result <= w_result_nxt;
      r_carry  <= w_carry_nxt;
      r_zero   <= w_zero_nxt;
      r_err    <= w_err_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign result = r_result;
  assign carry  = r_carry;
  assign zero   = r_zero;
  assign err    = r_err;
  assign done   = r_done;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//
// This is a directed bench for seq_alu. It uses two instances:
//   - u_dut4 with WIDTH=4
//   - u_dut8 with WIDTH=8
// Inputs change on the falling edge. Outputs are sampled on the falling edge,
// so a sample taken one negedge after driving start sees the result of the
// acceptance edge.
// MUL checks run only when SEQ_ALU_MUL_EN is defined. Otherwise, opcode 110
// is checked as a reserved op.
// -----------------------------------------------------------------------------
module tb_seq_alu;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  logic       s4;
  logic [2:0] op4;
  logic [3:0] a4, b4;
  logic       busy4, done4, carry4, zero4, err4;
  logic [7:0] res4;

  logic        s8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, carry8, zero8, err8;
  logic [15:0] res8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(s4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4), .carry(carry4),
    .zero(zero4), .err(err4)
  );

  seq_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(s8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .carry(carry8),
    .zero(zero8), .err(err8)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive4(input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b);
    s4 = 1'b1; op4 = op; a4 = a; b4 = b;
  endtask

  initial begin
    s4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
    s8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;

    // ---- reset values --------------------------------------------------
    #2 reset = 1'b1;
    #2;
    check("rst_busy",   busy4, 0);
    check("rst_done",   done4, 0);
    check("rst_result", res4,  0);
    check("rst_carry",  carry4, 0);
    check("rst_zero",   zero4, 1);
    check("rst_err",    err4,  0);
    check("rst_zero8",  zero8, 1);
    @(negedge clk);
    reset = 1'b0;

    // ---- ADD 9+8 = 17 -> 1, carry ---------------------------------------
    drive4(3'b000, 4'd9, 4'd8);
    @(negedge clk);
    s4 = 1'b0;
    check("add_done",   done4, 1);
    check("add_result", res4,  1);
    check("add_carry",  carry4, 1);
    check("add_zero",   zero4, 0);
    check("add_err",    err4,  0);
    @(negedge clk);
    check("add_done_drop", done4, 0);
    check("add_hold",      res4,  1);

    // ---- SUB 3-5 = 14, borrow; SUB 5-5 = 0, no borrow --------------------
    drive4(3'b001, 4'd3, 4'd5);
    @(negedge clk);
    check("sub35_result", res4,  14);
    check("sub35_carry",  carry4, 0);
    drive4(3'b001, 4'd5, 4'd5);
    @(negedge clk);
    s4 = 1'b0;
    check("sub55_done",   done4, 1);
    check("sub55_result", res4,  0);
    check("sub55_carry",  carry4, 1);
    check("sub55_zero",   zero4, 1);

    // ---- XOR / NOT ------------------------------------------------------
    drive4(3'b100, 4'd12, 4'd10);
    @(negedge clk);
    check("xor_result", res4, 6);
    drive4(3'b101, 4'd5, 4'd0);
    @(negedge clk);
    s4 = 1'b0;
    check("not_result", res4,  10);
    check("not_carry",  carry4, 0);

    // ---- reserved opcode 111 --------------------------------------------
    drive4(3'b111, 4'd7, 4'd3);
    @(negedge clk);
    s4 = 1'b0;
    check("rsv_done",   done4, 1);
    check("rsv_result", res4,  0);
    check("rsv_err",    err4,  1);
    check("rsv_zero",   zero4, 1);
    check("rsv_carry",  carry4, 0);
    @(negedge clk);

    // ---- WIDTH=8 ADD 200+100 = 300 -> 44, carry ---------------------------
    s8 = 1'b1; op8 = 3'b000; a8 = 8'd200; b8 = 8'd100;
    @(negedge clk);
    s8 = 1'b0;
    check("add8_result", res8,  44);
    check("add8_carry",  carry8, 1);

`ifdef SEQ_ALU_MUL_EN
    // ---- MUL 15x15, with an ADD issued at edge k+2 that must be ignored --
    drive4(3'b110, 4'd15, 4'd15);
    @(negedge clk);                       // after edge k
    s4 = 1'b0;
    check("mul_busy_k1", busy4, 1);
    check("mul_done_k1", done4, 0);
    drive4(3'b000, 4'd1, 4'd1);           // sampled on edge k+2
    @(negedge clk);                       // after edge k+1
    check("mul_busy_k2", busy4, 1);
    @(negedge clk);                       // after edge k+2
    s4 = 1'b0;
    check("mul_busy_k3",   busy4, 1);
    check("mul_done_k3",   done4, 0);
    check("mul_hold_err",  err4,  1);
    check("mul_hold_res",  res4,  0);
    @(negedge clk);                       // after edge k+3
    check("mul_busy_k4", busy4, 1);
    check("mul_done_k4", done4, 0);
    @(negedge clk);                       // after edge k+4
    check("mul_busy_end", busy4, 0);
    check("mul_done",     done4, 1);
    check("mul_result",   res4,  225);
    check("mul_err",      err4,  0);
    check("mul_zero",     zero4, 0);
    @(negedge clk);
    check("mul_one_done", done4, 0);
    check("mul_hold",     res4,  225);
`else
    // ---- MUL disabled: 110 acts as reserved -----------------------------
    drive4(3'b110, 4'd3, 4'd4);
    @(negedge clk);
    s4 = 1'b0;
    check("nomul_done",   done4, 1);
    check("nomul_busy",   busy4, 0);
    check("nomul_err",    err4,  1);
    check("nomul_result", res4,  0);
    check("nomul_zero",   zero4, 1);
    @(negedge clk);
    check("nomul_busy2",  busy4, 0);
`endif

    // ---- back-to-back AND then OR ---------------------------------------
    drive4(3'b010, 4'd12, 4'd10);
    @(negedge clk);
    check("b2b_and_done", done4, 1);
    check("b2b_and",      res4,  8);
    check("b2b_and_err",  err4,  0);
    drive4(3'b011, 4'd12, 4'd10);
    @(negedge clk);
    s4 = 1'b0;
    check("b2b_or_done", done4, 1);
    check("b2b_or",      res4,  14);
    @(negedge clk);
    check("b2b_done_drop", done4, 0);

`ifdef SEQ_ALU_MUL_EN
    // ---- reset between edges k+2 and k+3 of a MUL ------------------------
    drive4(3'b110, 4'd15, 4'd15);
    @(negedge clk);                       // after edge k
    s4 = 1'b0;
    @(negedge clk);                       // after edge k+1
    @(negedge clk);                       // after edge k+2
    reset = 1'b1;
    #1;
    check("rmid_busy",   busy4, 0);
    check("rmid_done",   done4, 0);
    check("rmid_result", res4,  0);
    check("rmid_zero",   zero4, 1);
    @(negedge clk);                       // edge k+3 passed under reset
    reset = 1'b0;
    drive4(3'b110, 4'd3, 4'd4);           // accepted on the first edge after release
    @(negedge clk);
    s4 = 1'b0;
    check("rmul_busy",    busy4, 1);
    check("rmul_no_done", done4, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rmul_no_done3", done4, 0);
    @(negedge clk);
    check("rmul_done",   done4, 1);
    check("rmul_result", res4,  12);

    // ---- WIDTH=8 MUL 255x255 = 65025 in 8 cycles --------------------------
    s8 = 1'b1; op8 = 3'b110; a8 = 8'd255; b8 = 8'd255;
    @(negedge clk);
    s8 = 1'b0;
    for (int i = 1; i < 8; i++) @(negedge clk);
    check("mul8_busy_k7", busy8, 1);
    check("mul8_done_k7", done8, 0);
    @(negedge clk);
    check("mul8_done",   done8, 1);
    check("mul8_busy",   busy8, 0);
    check("mul8_result", res8,  65025);
`else
    // ---- asynchronous reset clears outputs at once ---------------------
    reset = 1'b1;
    #1;
    check("rasync_result", res4,  0);
    check("rasync_zero",   zero4, 1);
    check("rasync_done",   done4, 0);
    @(negedge clk);
    reset = 1'b0;
    drive4(3'b000, 4'd3, 4'd4);
    @(negedge clk);
    s4 = 1'b0;
    check("rasync_add", res4, 7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
